// File: rtl/argo_pkg.sv
// Shared types and constants for the Argo channel reduce stage.
// State encoding and default widths live here.
package argo_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int FCNT_W     = 16;

endpackage

// File: rtl/argo_chan_reduce_if.sv
// Stream-in / sum-out handshake bundle for argo_chan_reduce.
// slave side is the reducer, master side is its environment.
interface argo_chan_reduce_if
  import argo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              ivalid;
  logic [DATA_W-1:0] datain;
  logic              oready;
  logic              ovalid;
  logic [DATA_W-1:0] dataout;
  logic              iready;
  logic [FCNT_W-1:0] frame_cnt;

  modport slave (
    input  ivalid,
    input  datain,
    input  iready,
    output oready,
    output ovalid,
    output dataout,
    output frame_cnt
  );

  modport master (
    output ivalid,
    output datain,
    output iready,
    input  oready,
    input  ovalid,
    input  dataout,
    input  frame_cnt
  );

endinterface

// File: rtl/argo_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate flag.
module argo_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign count = wptr - rptr;
  assign full  = (count == FULL_C);
  assign empty = (wptr == rptr);
  assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/argo_chan_reduce.sv
// Channel consumer: buffers incoming words and reduces each frame
// of FRAME_LEN words to one wrap-around sum on a handshake output.
module argo_chan_reduce
  import argo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 4
) (
  input logic clk,
  input logic rst,
  argo_chan_reduce_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST_C = IW'(FRAME_LEN-1);

  state_t            state;
  state_t            nstate;
  logic              run;
  logic [DATA_W-1:0] sum;
  logic [IW-1:0]     items;
  logic              ovalid_q;
  logic [DATA_W-1:0] dataout_q;
  logic [FCNT_W-1:0] fcnt;

  logic              push;
  logic              pop;
  logic              last;
  logic              hs;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] nsum;
  logic              full;
  logic              empty;
  logic [AW:0]       fill;

  // oready is purely registered: never looks at ivalid
  assign bus.oready = run && (fill != FULL_C);
  assign push = bus.ivalid && bus.oready && !full;

  argo_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.datain),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fill)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCUM;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (1'b1)
      state == ACCUM: if (pop && last) nstate = EMIT;
      state == EMIT:  if (bus.iready)  nstate = ACCUM;
      default:        nstate = ACCUM;
    endcase
  end

  always_comb begin
    pop  = (state == ACCUM) && !empty;
    last = (items == LAST_C);
    hs   = (state == EMIT) && bus.iready;
    nsum = sum + head;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run       <= 1'b0;
      sum       <= '0;
      items     <= '0;
      ovalid_q  <= 1'b0;
      dataout_q <= '0;
      fcnt      <= '0;
    end else begin
      run <= 1'b1;
      if (pop) begin
        if (last) begin
          sum       <= '0;
          items     <= '0;
          dataout_q <= nsum;
          ovalid_q  <= 1'b1;
        end else begin
          sum   <= nsum;
          items <= items + 1'b1;
        end
      end
      if (hs) begin
        ovalid_q <= 1'b0;
        fcnt     <= fcnt + 1'b1;
      end
    end
  end

  assign bus.ovalid    = ovalid_q;
  assign bus.dataout   = dataout_q;
  assign bus.frame_cnt = fcnt;

endmodule

// File: tb/tb_argo_chan_reduce.sv
// Directed bench for argo_chan_reduce with a frame-level scoreboard
// checked every cycle plus literal expectations per scenario.
module tb_argo_chan_reduce;

  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  argo_chan_reduce_if bus ();

  argo_chan_reduce #(
    .DATA_W    (32),
    .DEPTH     (4),
    .FRAME_LEN (FL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // frame-level model: accepted words fold into expected sums
  logic [31:0] exp_q [$];
  logic [31:0] seen [$];
  logic [31:0] m_acc = '0;
  int          m_n = 0;
  logic [15:0] m_fcnt = '0;
  logic        p_push = 1'b0;
  logic        p_hs = 1'b0;
  logic [31:0] p_word = '0;
  logic [31:0] p_dout = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ovalid", {31'd0, bus.ovalid}, 32'd0);
      chk("rst_oready", {31'd0, bus.oready}, 32'd0);
      chk("rst_dataout", bus.dataout, 32'd0);
      chk("rst_fcnt", {16'd0, bus.frame_cnt}, 32'd0);
      p_push = 1'b0;
      p_hs   = 1'b0;
    end else begin
      chk("frame_cnt", {16'd0, bus.frame_cnt}, {16'd0, m_fcnt});
      if (bus.ovalid) begin
        if (exp_q.size() == 0)
          chk("spurious_ovalid", 32'd1, 32'd0);
        else
          chk("dataout", bus.dataout, exp_q[0]);
      end
      p_push = bus.ivalid && bus.oready;
      p_word = bus.datain;
      p_hs   = bus.ovalid && bus.iready;
      p_dout = bus.dataout;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      seen.delete();
      m_acc  = '0;
      m_n    = 0;
      m_fcnt = '0;
    end else begin
      if (p_push) begin
        m_acc = m_acc + p_word;
        m_n++;
        if (m_n == FL) begin
          exp_q.push_back(m_acc);
          m_acc = '0;
          m_n   = 0;
        end
      end
      if (p_hs) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        seen.push_back(p_dout);
        m_fcnt = m_fcnt + 16'd1;
      end
    end
    p_push = 1'b0;
    p_hs   = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    logic ok;
    bus.ivalid = 1'b1;
    bus.datain = w;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ok = bus.oready;
      tick();
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ovalid();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.ovalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("ovalid_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.ivalid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ivalid = 1'b1;
    bus.datain = 32'd55;
    bus.iready = 1'b0;

    // reset held with ivalid high
    repeat (3) begin
      tick();
      chk("r_ovalid", {31'd0, bus.ovalid}, 32'd0);
      chk("r_oready", {31'd0, bus.oready}, 32'd0);
      chk("r_dataout", bus.dataout, 32'd0);
    end
    rst = 1'b1;
    bus.ivalid = 1'b0;
    chk("r_oready_rel", {31'd0, bus.oready}, 32'd0);
    tick();
    chk("r_oready_up", {31'd0, bus.oready}, 32'd1);

    // basic frame with latency pin
    bus.iready = 1'b1;
    for (int k = 1; k <= 4; k++) send(32'(k));
    bus.ivalid = 1'b0;
    chk("b_ovalid_lo", {31'd0, bus.ovalid}, 32'd0);
    tick();
    chk("b_ovalid_hi", {31'd0, bus.ovalid}, 32'd1);
    chk("b_dataout", bus.dataout, 32'd10);
    tick();
    chk("b_ovalid_1cyc", {31'd0, bus.ovalid}, 32'd0);
    chk("b_fcnt", {16'd0, bus.frame_cnt}, 32'd1);

    // backpressure: sum 10 held while 5..8 fill the FIFO
    do_reset();
    bus.iready = 1'b0;
    for (int k = 1; k <= 8; k++) send(32'(k));
    chk("bp_full", {31'd0, bus.oready}, 32'd0);
    bus.ivalid = 1'b1;
    bus.datain = 32'd9;
    repeat (3) begin
      tick();
      chk("bp_oready", {31'd0, bus.oready}, 32'd0);
      chk("bp_ovalid", {31'd0, bus.ovalid}, 32'd1);
      chk("bp_hold", bus.dataout, 32'd10);
    end
    bus.iready = 1'b1;
    send(32'd9);
    bus.ivalid = 1'b0;
    wait_ovalid();
    chk("bp_second", bus.dataout, 32'd26);
    tick();
    chk("bp_fcnt", {16'd0, bus.frame_cnt}, 32'd2);

    // carry discarded on wrap-around
    do_reset();
    send(32'hFFFF_FFFF);
    send(32'd2);
    send(32'd0);
    send(32'd0);
    bus.ivalid = 1'b0;
    wait_ovalid();
    chk("wrap_sum", bus.dataout, 32'd1);
    tick();

    // async reset between edges drops a partial frame
    send(32'd7);
    send(32'd7);
    bus.ivalid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mr_ovalid", {31'd0, bus.ovalid}, 32'd0);
    chk("mr_oready", {31'd0, bus.oready}, 32'd0);
    chk("mr_dataout", bus.dataout, 32'd0);
    chk("mr_fcnt", {16'd0, bus.frame_cnt}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) send(32'd5);
    bus.ivalid = 1'b0;
    wait_ovalid();
    chk("mr_sum", bus.dataout, 32'd20);
    tick();
    chk("mr_fcnt1", {16'd0, bus.frame_cnt}, 32'd1);

    // long stream wraps the FIFO pointers many times
    do_reset();
    for (int k = 1; k <= 32; k++) send(32'(k));
    bus.ivalid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.frame_cnt == 16'd8) break;
      tick();
    end
    tick();
    chk("s_fcnt", {16'd0, bus.frame_cnt}, 32'd8);
    chk("s_nsums", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < seen.size())
        chk("s_sum", seen[i], 32'(10 + 16 * i));
    end
    chk("s_pending", 32'(exp_q.size()), 32'd0);
    chk("s_partial", 32'(m_n), 32'd0);
    chk("s_idle", {31'd0, bus.ovalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
